// File: rtl/pool1_maxpool_stage.sv
// -----------------------------------------------------------------------------
// pool1_maxpool_stage
//   2x2 / stride-2 signed max-pool between the conv1 feature-map memory and the
//   P1 memory. One start pulse (sampled in IDLE) processes one IN_DIM x IN_DIM
//   map: each RUN cycle issues the four taps of one window, the tap data returns
//   one cycle later, and the pooled (optionally ReLU-clamped) value is written
//   on the following cycle, in raster order.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 begin one map (ignored unless IDLE)
//   busy                  high whenever the block is not IDLE
//   done                  one-cycle pulse after the last write
//   rd_en, rd_addr0..3    window tap read strobe / addresses (TL, TR, BL, BR)
//   rd_data0..3           tap data, valid one cycle after rd_en
//   wr_en, wr_addr        P1 write strobe / pooled index
//   wr_data               pooled value
// -----------------------------------------------------------------------------
module pool1_maxpool_stage #(
    parameter int IN_DIM = 32'sd24,
    parameter int DATA_W = 32'sd16,
    parameter int IN_AW  = 32'sd10,
    parameter int OUT_AW = 32'sd8,
    parameter bit RELU   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [IN_AW-1:0]  rd_addr0,
    output logic [IN_AW-1:0]  rd_addr1,
    output logic [IN_AW-1:0]  rd_addr2,
    output logic [IN_AW-1:0]  rd_addr3,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] rd_data3,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int HALF = IN_DIM / 32'sd2;
    localparam int NWIN = HALF * HALF;
    localparam int CW   = (HALF > 32'sd1) ? $clog2(HALF) : 32'sd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CW-1:0]       col_r;
    logic [CW-1:0]       row_r;
    logic [CW-1:0]       col_nxt_s;
    logic [CW-1:0]       row_nxt_s;
    logic [IN_AW-1:0]    base_nxt_s;
    logic                drain_cnt_r;
    logic                rd_vld_r;
    logic [OUT_AW-1:0]   wr_idx_r;
    logic                last_win_s;
    logic signed [DATA_W-1:0] max_s;
    logic [DATA_W-1:0]   pooled_s;

    // Signed maximum of two taps at full pixel width.
    function automatic logic signed [DATA_W-1:0] max2(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    assign last_win_s = (col_r == CW'(HALF - 32'sd1)) && (row_r == CW'(HALF - 32'sd1));

    // Next-state logic; DRAIN lasts two cycles so the final two writes land.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_win_s) state_nxt_s = ST_DRAIN;
                else            state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (drain_cnt_r) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_DRAIN;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Window walk: base (top-left tap) steps by 2 per column and jumps to the
    // next pair of rows on column wrap; everything rewinds after the last window.
    always_comb begin
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        base_nxt_s = rd_addr0;
        if (state_r == ST_RUN) begin
            if (last_win_s) begin
                col_nxt_s  = {CW{1'b0}};
                row_nxt_s  = {CW{1'b0}};
                base_nxt_s = {IN_AW{1'b0}};
            end else if (col_r == CW'(HALF - 32'sd1)) begin
                col_nxt_s  = {CW{1'b0}};
                row_nxt_s  = row_r + CW'(1'b1);
                base_nxt_s = rd_addr0 + IN_AW'(IN_DIM + 32'sd2);
            end else begin
                col_nxt_s  = col_r + CW'(1'b1);
                row_nxt_s  = row_r;
                base_nxt_s = rd_addr0 + IN_AW'(2'd2);
            end
        end else begin
            col_nxt_s  = col_r;
            row_nxt_s  = row_r;
            base_nxt_s = rd_addr0;
        end
    end

    // Pool the four returned taps and clamp negative maxima when ReLU is on.
    always_comb begin
        max_s = max2(max2($signed(rd_data0), $signed(rd_data1)),
                     max2($signed(rd_data2), $signed(rd_data3)));
        if (RELU && max_s[DATA_W-1]) pooled_s = {DATA_W{1'b0}};
        else                         pooled_s = max_s;
    end

    // State, counters and registered control/address outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            col_r       <= {CW{1'b0}};
            row_r       <= {CW{1'b0}};
            drain_cnt_r <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr0    <= {IN_AW{1'b0}};
            rd_addr1    <= {IN_AW{1'b0}};
            rd_addr2    <= {IN_AW{1'b0}};
            rd_addr3    <= {IN_AW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            col_r       <= col_nxt_s;
            row_r       <= row_nxt_s;
            drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
            busy        <= (state_nxt_s != ST_IDLE);
            done        <= (state_nxt_s == ST_DONE);
            rd_en       <= (state_nxt_s == ST_RUN);
            rd_addr0    <= base_nxt_s;
            rd_addr1    <= base_nxt_s + IN_AW'(1'b1);
            rd_addr2    <= base_nxt_s + IN_AW'(IN_DIM);
            rd_addr3    <= base_nxt_s + IN_AW'(IN_DIM + 32'sd1);
        end
    end

    // Write pipeline: rd_vld_r marks the cycle tap data is present; the pooled
    // value is registered on the following edge with a free-running index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_r <= 1'b0;
            wr_en    <= 1'b0;
            wr_idx_r <= {OUT_AW{1'b0}};
            wr_addr  <= {OUT_AW{1'b0}};
            wr_data  <= {DATA_W{1'b0}};
        end else begin
            rd_vld_r <= rd_en;
            wr_en    <= rd_vld_r;
            if (rd_vld_r) begin
                wr_addr  <= wr_idx_r;
                wr_data  <= pooled_s;
                wr_idx_r <= (wr_idx_r == OUT_AW'(NWIN - 32'sd1)) ? {OUT_AW{1'b0}}
                                                                 : wr_idx_r + OUT_AW'(1'b1);
            end else begin
                wr_addr  <= wr_addr;
                wr_data  <= wr_data;
                wr_idx_r <= wr_idx_r;
            end
        end
    end

endmodule
